// File: rtl/rx_phy_if.sv
// Received byte stream and per-frame status produced by rx_phy.
// The master drives the stream; a downstream consumer uses the slave view.
interface rx_phy_if;
  logic [7:0]  M_DATA;
  logic        M_VALID;
  logic        M_SOF;
  logic        M_EOF;
  logic        M_ERR;
  logic        STAT_VALID;
  logic [10:0] STAT_LEN;
  logic        STAT_CRC_OK;

  modport master (
    output M_DATA, M_VALID, M_SOF, M_EOF, M_ERR,
    output STAT_VALID, STAT_LEN, STAT_CRC_OK
  );

  modport slave (
    input M_DATA, M_VALID, M_SOF, M_EOF, M_ERR,
    input STAT_VALID, STAT_LEN, STAT_CRC_OK
  );
endinterface

// File: rtl/rx_phy.sv
// RGMII receive framer: strips preamble/SFD and emits bytes with sof/eof/err and per-frame status.
// Optional FCS checking is compiled in when RX_CRC_CHECK_EN is defined.
module rx_phy #(
  parameter int MIN_PRE = 1,
  parameter int MAX_LEN = 1518
) (
  input  logic        ETH_RXCLK,
  input  logic        RSTN,
  input  logic [3:0]  RXD_R,
  input  logic [3:0]  RXD_F,
  input  logic        RXCTL_R,
  input  logic        RXCTL_F,
  rx_phy_if.master    m,
  output logic [15:0] FRAME_CNT,
  output logic [15:0] DROP_CNT
);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_e;

  // Input stage
  logic [7:0] in_byte_q;
  logic       in_dv_q;
  logic       in_er_q;

  // NOTE: reset is synchronous, so it lives inside the clocked block and is sampled on the edge.
  always_ff @(posedge ETH_RXCLK) begin
    if (!RSTN) begin
      in_byte_q <= 8'h00;
      in_dv_q   <= 1'b1;
      in_er_q   <= 1'b0;
    end else begin
      in_byte_q <= {RXD_F, RXD_R};
      in_dv_q   <= RXCTL_R;
      in_er_q   <= RXCTL_R ^ RXCTL_F;
    end
  end

  // Framer state
  state_e      state_q;
  logic        prev_dv_q;
  logic [2:0]  pre_cnt_q;
  logic [10:0] len_q;
  logic        sticky_q;
  logic        have_q;
  logic        sof_pend_q;
  logic [7:0]  hold_q;

  logic [7:0]  data_q;
  logic        valid_q;
  logic        sof_q;
  logic        eof_q;
  logic        err_q;
  logic        stat_valid_q;
  logic [10:0] stat_len_q;
  logic        stat_crc_ok_q;
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  logic        dv_rise;
  logic        pre_ok;
  logic [2:0]  pre_cnt_d;
  logic [11:0] len_inc;
  logic [10:0] len_d;
  logic        oversize;
  logic        crc_ok;
  logic        crc_fail;

  assign dv_rise   = in_dv_q & ~prev_dv_q;
  assign pre_ok    = int'(pre_cnt_q) >= MIN_PRE;
  assign pre_cnt_d = (pre_cnt_q == 3'd7) ? pre_cnt_q : pre_cnt_q + 3'd1;
  assign len_inc   = {1'b0, len_q} + 12'd1;
  assign len_d     = (len_q == 11'h7FF) ? len_q : len_inc[10:0];
  assign oversize  = int'(len_inc) > MAX_LEN;

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_d;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_d    = crc_step(crc_q, in_byte_q);
  // Register value left after a frame whose appended FCS is correct.
  assign crc_ok   = (crc_q == 32'hDEBB20E3);
  assign crc_fail = ~crc_ok;

  always_ff @(posedge ETH_RXCLK) begin
    if (!RSTN) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (state_q == PRE) begin
      crc_q <= 32'hFFFFFFFF;
    end else if (state_q == DATA && in_dv_q) begin
      crc_q <= crc_d;
    end
  end
`else
  assign crc_ok   = 1'b0;
  assign crc_fail = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge ETH_RXCLK) begin
    if (!RSTN) begin
      state_q       <= IDLE;
      prev_dv_q     <= 1'b1;
      pre_cnt_q     <= 3'd0;
      len_q         <= 11'd0;
      sticky_q      <= 1'b0;
      have_q        <= 1'b0;
      sof_pend_q    <= 1'b0;
      hold_q        <= 8'h00;
      data_q        <= 8'h00;
      valid_q       <= 1'b0;
      sof_q         <= 1'b0;
      eof_q         <= 1'b0;
      err_q         <= 1'b0;
      stat_valid_q  <= 1'b0;
      stat_len_q    <= 11'd0;
      stat_crc_ok_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
      drop_cnt_q    <= 16'd0;
    end else begin
      prev_dv_q    <= in_dv_q;
      valid_q      <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      err_q        <= 1'b0;
      stat_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (dv_rise) begin
            if (in_byte_q == 8'h55) begin
              state_q   <= PRE;
              pre_cnt_q <= 3'd1;
            end else begin
              state_q <= DROP;
            end
          end
        end

        PRE: begin
          if (!in_dv_q) begin
            state_q    <= IDLE;
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end else if (in_er_q) begin
            state_q    <= DROP;
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end else if (in_byte_q == 8'h55) begin
            pre_cnt_q <= pre_cnt_d;
          end else if (in_byte_q == 8'hD5 && pre_ok) begin
            state_q    <= DATA;
            len_q      <= 11'd0;
            sticky_q   <= 1'b0;
            have_q     <= 1'b0;
            sof_pend_q <= 1'b1;
          end else begin
            state_q    <= DROP;
            drop_cnt_q <= drop_cnt_q + 16'd1;
          end
        end

        DATA: begin
          // Emitting lags reception by one byte so the final byte can carry eof.
          if (have_q) begin
            data_q     <= hold_q;
            valid_q    <= 1'b1;
            sof_q      <= sof_pend_q;
            sof_pend_q <= 1'b0;
          end

          if (in_dv_q) begin
            if (oversize) begin
              eof_q         <= 1'b1;
              err_q         <= 1'b1;
              stat_valid_q  <= 1'b1;
              stat_len_q    <= len_q;
              stat_crc_ok_q <= 1'b0;
              drop_cnt_q    <= drop_cnt_q + 16'd1;
              have_q        <= 1'b0;
              state_q       <= DROP;
            end else begin
              hold_q   <= in_byte_q;
              have_q   <= 1'b1;
              len_q    <= len_d;
              sticky_q <= sticky_q | in_er_q;
            end
          end else begin
            state_q <= IDLE;
            have_q  <= 1'b0;
            if (have_q) begin
              eof_q         <= 1'b1;
              err_q         <= sticky_q | crc_fail;
              stat_valid_q  <= 1'b1;
              stat_len_q    <= len_q;
              stat_crc_ok_q <= crc_ok;
              if (sticky_q | crc_fail) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
              end else begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
              end
            end else begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
            end
          end
        end

        DROP: begin
          if (!in_dv_q) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m.M_DATA      = data_q;
  assign m.M_VALID     = valid_q;
  assign m.M_SOF       = sof_q;
  assign m.M_EOF       = eof_q;
  assign m.M_ERR       = err_q;
  assign m.STAT_VALID  = stat_valid_q;
  assign m.STAT_LEN    = stat_len_q;
  assign m.STAT_CRC_OK = stat_crc_ok_q;
  assign FRAME_CNT     = frame_cnt_q;
  assign DROP_CNT      = drop_cnt_q;

endmodule
